gf163_digit_mult: RTL and testbench
===================================

Name: gf163_digit_mult

Overview:
- Sequential digit-serial GF(2^163) multiplier datapath and control. It wraps the existing combinational accumulator/reduction stage.
- Each cycle it forms the two 163x41 carry-less digit partial products that feed the accumulator's A and B inputs. It registers the accumulator's reduced 163-bit output and feeds it back as the accumulator's C input.
- The multiplicand B is processed MSB-first, 82 bits per iteration, in 2 iterations. Result is A*B mod P(x), where P(x) = x^163 + x^7 + x^6 + x^3 + 1.
- The block sits between the point-arithmetic sequencer and the accumulator.

Parameters:
- DIGIT_W, 41: digit width. Fixed; other values unsupported.
- NUM_ITER, 2: iterations per multiply. Fixed; equals ceil(164/82).

Ports:
- MUL_CLK  input  1  clock, rising edge.
- MUL_RST  input  1  asynchronous, active-high reset.
- MUL_START  input  1  start request; sampled only in IDLE.
- MUL_A  input  163  multiplicand; captured on the accepted start.
- MUL_B  input  163  multiplier; captured on the accepted start.
- MUL_BUSY  output  1  high while a multiply is in flight.
- MUL_DONE  output  1  one-cycle pulse; MUL_C valid.
- MUL_C  output  163  product A*B mod P(x); held until the next accepted start.

Behaviour:
- Reset (async, MUL_RST=1): state=IDLE, iteration counter=0, A/B/C registers=0, MUL_BUSY=0, MUL_DONE=0, MUL_C=0. Reset mid-operation aborts the multiply; no DONE is produced.
- B register is 164 bits: MUL_B zero-extended by 1 bit, digits d3..d0 of 41 bits each, d3 = bits[163:123].
- States:
  - IDLE: MUL_START=1 at edge k -> capture A and B, clear C, cnt=0, go to RUN.
  - RUN: each edge does C <= acc_out and cnt <= cnt+1. On the edge where cnt==1 -> DONE.
  - DONE: MUL_DONE=1 for exactly one cycle; next edge -> IDLE.
- Iteration cnt uses digit pair (hi, lo):
  - cnt=0: hi=d3, lo=d2.
  - cnt=1: hi=d1, lo=d0.
- Accumulator drive:
  - ACC_B input = clmul(A, hi), 203 bits.
  - ACC_A input = clmul(A, lo), 203 bits.
  - ACC_C input = C register.
  - acc_out = reduce(C*x^82 + ACC_B*x^41 + ACC_A).
- clmul: 163x41 carry-less product, bit i = XOR over j of A[i-j] & d[j], width 203. Purely combinational inside this block.
- Timing: start sampled at edge k; C updated at edges k+1 and k+2; MUL_DONE high from edge k+2 to edge k+3; MUL_BUSY high from edge k to edge k+2. Start-to-done latency is 2 cycles after acceptance; throughput is one multiply per 3 cycles.
- MUL_BUSY = (state==RUN). MUL_BUSY is low in DONE so the sequencer may assert MUL_START during the DONE cycle; that start is accepted at the edge leaving DONE. Exception: DONE goes directly back to RUN if MUL_START=1, giving back-to-back multiplies every 3 cycles.
- MUL_START while in RUN is ignored; operands are not recaptured.
- MUL_C is driven directly from the C register. Its value during RUN is intermediate and must not be used; it is only valid from DONE until the next accepted start.
- Operands A=0 or B=0 -> MUL_C=0. MUL_B[162] set is handled via the zero-extended top bit of d3.

Optional Feature:
- Macro MUL_FWD_EN.
- Defined: adds input port MUL_FWD (1 bit). If MUL_FWD=1 on an accepted start, operand A is taken from the current C register (previous result) instead of MUL_A; MUL_B is captured normally. MUL_FWD is ignored when no start is accepted. MUL_FWD after reset selects C=0, so the product is 0.
- Undefined: port absent; A always comes from MUL_A.

Test Plan:
- Reset, then A=1, B=1, start -> MUL_DONE exactly 2 cycles after start acceptance, MUL_C=1, MUL_BUSY high for 2 cycles.
- A=x^162 (bit 162 only), B=x (0x2) -> MUL_C=0xC9, i.e. x^7+x^6+x^3+1.
- A=all-ones 163-bit, B=0 -> MUL_C=0. Then A=0x5, B=0x3 -> MUL_C=0xF, i.e. (x^2+1)(x+1).
- Start with A=1, B=1; assert MUL_START with A=3, B=3 during RUN -> ignored, MUL_C=1. Start again during the DONE cycle -> accepted, next result 0x5.
- Start A=x^81, B=x^81, then assert MUL_RST one cycle later -> MUL_DONE never pulses, MUL_C=0, state IDLE. Rerun without reset -> MUL_C=x^162.
- (MUL_FWD_EN) A=x^81, B=x^81 -> x^162. Then start with MUL_FWD=1, B=x -> MUL_C=0xC9.

Source files
------------

// File: rtl/gf163_digit_mult.sv
// Digit-serial GF(2^163) multiplier, P(x) = x^163 + x^7 + x^6 + x^3 + 1, two 82-bit iterations.
// Optional macro MUL_FWD_EN adds MUL_FWD to take operand A from the previous result.
module gf163_digit_mult #(
    parameter int unsigned DIGIT_W  = 41,
    parameter int unsigned NUM_ITER = 2
) (
    input  logic         MUL_CLK,
    input  logic         MUL_RST,
    input  logic         MUL_START,
`ifdef MUL_FWD_EN
    input  logic         MUL_FWD,
`endif
    input  logic [162:0] MUL_A,
    input  logic [162:0] MUL_B,
    output logic         MUL_BUSY,
    output logic         MUL_DONE,
    output logic [162:0] MUL_C
);

    localparam int unsigned FW    = 163;
    localparam int unsigned BW    = 2 * DIGIT_W * NUM_ITER;
    localparam int unsigned PW    = FW + DIGIT_W - 1;
    localparam int unsigned SW    = FW + 2 * DIGIT_W;
    localparam int unsigned CNT_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ITER - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [FW-1:0]    a_q;
    logic [BW-1:0]    b_q;
    logic [FW-1:0]    c_q;
    logic             busy_q;
    logic             done_q;

    logic [FW-1:0]      a_src;
    logic [BW-1:0]      b_win;
    logic [DIGIT_W-1:0] hi_digit;
    logic [DIGIT_W-1:0] lo_digit;
    logic [PW-1:0]      acc_a;
    logic [PW-1:0]      acc_b;
    logic [SW-1:0]      acc_sum;
    logic [FW-1:0]      acc_out;

    function automatic logic [PW-1:0] clmul(input logic [FW-1:0] a, input logic [DIGIT_W-1:0] d);
        logic [PW-1:0] r;
        r = '0;
        for (int j = 0; j < int'(DIGIT_W); j++) begin
            if (d[j]) r = r ^ ({{(DIGIT_W - 1){1'b0}}, a} << j);
        end
        return r;
    endfunction

    // Folds every bit at or above x^163 back down, highest first, so cascades settle.
    function automatic logic [FW-1:0] reduce(input logic [SW-1:0] v_in);
        logic [SW-1:0] v;
        v = v_in;
        for (int i = int'(SW) - 1; i >= int'(FW); i--) begin
            if (v[i]) begin
                v[i]       = 1'b0;
                v[i - 163] = ~v[i - 163];
                v[i - 160] = ~v[i - 160];
                v[i - 157] = ~v[i - 157];
                v[i - 156] = ~v[i - 156];
            end
        end
        return v[FW-1:0];
    endfunction

`ifdef MUL_FWD_EN
    assign a_src = MUL_FWD ? c_q : MUL_A;
`else
    assign a_src = MUL_A;
`endif

    // Shift the wanted digit pair to the top of the window: cnt 0 -> d3/d2, cnt 1 -> d1/d0.
    always_comb begin
        b_win    = b_q << (2 * DIGIT_W * cnt_q);
        hi_digit = b_win[BW-1 -: DIGIT_W];
        lo_digit = b_win[BW-1-DIGIT_W -: DIGIT_W];
        acc_b    = clmul(a_q, hi_digit);
        acc_a    = clmul(a_q, lo_digit);
        acc_sum  = {c_q, {(2 * DIGIT_W){1'b0}}}
                 ^ {1'b0, acc_b, {DIGIT_W{1'b0}}}
                 ^ {{(SW - PW){1'b0}}, acc_a};
        acc_out  = reduce(acc_sum);
    end

    always_ff @(posedge MUL_CLK or posedge MUL_RST) begin
        if (MUL_RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (MUL_START) begin
                        a_q     <= a_src;
                        b_q     <= {{(BW - FW){1'b0}}, MUL_B};
                        c_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    c_q   <= acc_out;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign MUL_BUSY = busy_q;
    assign MUL_DONE = done_q;
    assign MUL_C    = c_q;

endmodule

// File: tb/tb_gf163_digit_mult.sv
// Self-checking bench for gf163_digit_mult: directed cases plus random operands against a
// shift-and-add GF(2^163) reference model.
module tb_gf163_digit_mult;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [162:0] a = '0;
    logic [162:0] b = '0;
    logic         busy;
    logic         done;
    logic [162:0] c;
`ifdef MUL_FWD_EN
    logic         fwd = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gf163_digit_mult dut (
        .MUL_CLK  (clk),
        .MUL_RST  (rst),
        .MUL_START(start),
`ifdef MUL_FWD_EN
        .MUL_FWD  (fwd),
`endif
        .MUL_A    (a),
        .MUL_B    (b),
        .MUL_BUSY (busy),
        .MUL_DONE (done),
        .MUL_C    (c)
    );

    // Multiply by x modulo P(x); x^163 folds to x^7+x^6+x^3+1 = 0xC9.
    function automatic logic [162:0] xtime(input logic [162:0] v);
        logic top;
        top = v[162];
        v   = v << 1;
        if (top) v = v ^ 163'hC9;
        return v;
    endfunction

    // Horner evaluation over the bits of b, MSB first.
    function automatic logic [162:0] ref_mul(input logic [162:0] x, input logic [162:0] y);
        logic [162:0] r;
        r = '0;
        for (int i = 162; i >= 0; i--) begin
            r = xtime(r);
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[162:0];
    endfunction

    task automatic check(input string tag, input logic [162:0] obs, input logic [162:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_mul(input logic [162:0] ta, input logic [162:0] tb_op, input logic tf,
                           output int lat, output int busy_cycles);
        @(negedge clk);
        a     = ta;
        b     = tb_op;
        start = 1'b1;
`ifdef MUL_FWD_EN
        fwd   = tf;
`else
        if (tf) $display("note: forwarding requested without MUL_FWD_EN");
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef MUL_FWD_EN
        fwd   = 1'b0;
`endif
        lat         = -1;
        busy_cycles = 0;
        for (int i = 1; i <= 10; i++) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic mul_check(input string tag, input logic [162:0] ta, input logic [162:0] tb_op,
                             input logic tf, input logic [162:0] exp);
        int lat;
        int bc;
        run_mul(ta, tb_op, tf, lat, bc);
        check({tag, "_lat"}, 163'(lat), 163'd2);
        check({tag, "_busy"}, 163'(bc), 163'd2);
        check(tag, c, exp);
    endtask

    initial begin
        logic [162:0] ra;
        logic [162:0] rb;
        logic         saw_done;

        #2 rst = 1'b1;
        #10;
        check("rst_busy", {162'd0, busy}, 163'd0);
        check("rst_done", {162'd0, done}, 163'd0);
        check("rst_c", c, 163'd0);
        @(negedge clk);
        rst = 1'b0;

        mul_check("one_one", 163'd1, 163'd1, 1'b0, 163'd1);
        @(posedge clk);
        #1;
        check("done_pulse_width", {162'd0, done}, 163'd0);

        mul_check("x162_x", 163'd1 << 162, 163'd2, 1'b0, 163'hC9);
        mul_check("x_x162", 163'd2, 163'd1 << 162, 1'b0, 163'hC9);
        mul_check("ones_zero", {163{1'b1}}, 163'd0, 1'b0, 163'd0);
        mul_check("zero_rnd", 163'd0, rnd163(), 1'b0, 163'd0);
        mul_check("five_three", 163'd5, 163'd3, 1'b0, 163'hF);

        // Start held through RUN is ignored; the same start seen in DONE is accepted.
        @(negedge clk);
        a = 163'd1;
        b = 163'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 163'd3;
        b = 163'd3;
        @(posedge clk);
        #1;
        check("ign_busy", {162'd0, busy}, 163'd1);
        @(posedge clk);
        #1;
        check("ign_done", {162'd0, done}, 163'd1);
        check("ign_c", c, 163'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_done_low", {162'd0, done}, 163'd0);
        check("b2b_busy", {162'd0, busy}, 163'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("b2b_done", {162'd0, done}, 163'd1);
        check("b2b_c", c, 163'h5);

        // Reset mid-operation aborts without a DONE pulse.
        @(negedge clk);
        a = 163'd1 << 81;
        b = 163'd1 << 81;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_c", c, 163'd0);
        check("abort_busy", {162'd0, busy}, 163'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {162'd0, saw_done}, 163'd0);
        check("abort_idle_c", c, 163'd0);
        mul_check("rerun_x81sq", 163'd1 << 81, 163'd1 << 81, 1'b0, 163'd1 << 162);

        for (int k = 0; k < 10; k++) begin
            ra = rnd163();
            rb = rnd163();
            if (k == 0) rb[162] = 1'b1;
            mul_check($sformatf("rnd%0d", k), ra, rb, 1'b0, ref_mul(ra, rb));
        end

`ifdef MUL_FWD_EN
        mul_check("fwd_setup", 163'd1 << 81, 163'd1 << 81, 1'b0, 163'd1 << 162);
        mul_check("fwd_x", 163'd0, 163'd2, 1'b1, 163'hC9);
        ra = rnd163();
        rb = rnd163();
        mul_check("fwd_chain0", ra, rb, 1'b0, ref_mul(ra, rb));
        mul_check("fwd_chain1", 163'd0, rb, 1'b1, ref_mul(ref_mul(ra, rb), rb));
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
